// File: rtl/io_bus_sequencer.sv
// io_bus_sequencer
//   Turns a single-cycle FemtoRV32 IO request into a timed device access
//   (setup / strobe / hold) with active-low chip selects and strobes, and
//   keeps the CPU stalled through rbusy/wbusy until the access completes.
//
//   state  | meaning
//   IDLE   | waiting for a CPU request in IO space
//   SETUP  | cs low, strobes high, SETUP_CYCLES cycles
//   STROBE | rd_n or wr_n low, STROBE_CYCLES cycles minimum
//   WAIT   | strobe held low until dev_ready or timeout
//   HOLD   | strobes high, cs still low, HOLD_CYCLES cycles
//   DONE   | cs released, busy dropped, back to IDLE next cycle
//
// Ports
//   clk_i, reset_i        clock, synchronous active-low reset
//   sel_i, addr_i         IO region select, byte address ([7:4] device)
//   wdata_i, wmask_i      CPU write data / mask (non-zero mask = write)
//   rstrb_i               CPU read strobe
//   rdata_o               captured read data
//   rbusy_o, wbusy_o      access in progress
//   dev_cs_n_o            one-hot active-low device select
//   dev_rd_n_o/dev_wr_n_o active-low strobes
//   dev_addr_o/dev_wdata_o latched register address and write byte
//   dev_rdata_i, dev_ready_i device response
//   timeout_err_o         sticky abort flag
module io_bus_sequencer #(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned HOLD_CYCLES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sel_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wmask_i,
  input  logic        rstrb_i,
  output logic [31:0] rdata_o,
  output logic        rbusy_o,
  output logic        wbusy_o,
  output logic [15:0] dev_cs_n_o,
  output logic        dev_rd_n_o,
  output logic        dev_wr_n_o,
  output logic [3:0]  dev_addr_o,
  output logic [7:0]  dev_wdata_o,
  input  logic [7:0]  dev_rdata_i,
  input  logic        dev_ready_i,
  output logic        timeout_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_WAIT, ST_HOLD, ST_DONE
  } state_t;

  // Phase counter is loaded with (cycles - 1) and the phase ends at zero.
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        is_wr_q;
  logic [15:0] cs_n_q;
  logic        rd_n_q;
  logic        wr_n_q;
  logic        rbusy_q;
  logic        wbusy_q;
  logic [3:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [31:0] rdata_q;
  logic        terr_q;

  logic req;
  logic req_wr;
  assign req    = sel_i && (rstrb_i || (wmask_i != 4'b0000));
  // A write mask wins over a simultaneous read strobe.
  assign req_wr = (wmask_i != 4'b0000);

  logic unused_wdata;
  assign unused_wdata = ^wdata_i[31:8];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      is_wr_q <= 1'b0;
      cs_n_q  <= 16'hFFFF;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rbusy_q <= 1'b0;
      wbusy_q <= 1'b0;
      addr_q  <= 4'd0;
      wdata_q <= 8'd0;
      rdata_q <= 32'd0;
      terr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q <= ST_SETUP;
            cnt_q   <= SETUP_LD;
            is_wr_q <= req_wr;
            cs_n_q  <= ~(16'h0001 << addr_i[7:4]);
            addr_q  <= addr_i[3:0];
            wdata_q <= wdata_i[7:0];
            rbusy_q <= ~req_wr;
            wbusy_q <= req_wr;
          end
        end
        ST_SETUP: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_STROBE;
            cnt_q   <= STROBE_LD;
            rd_n_q  <= is_wr_q;
            wr_n_q  <= ~is_wr_q;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == 8'd0) begin
            if (dev_ready_i) begin
              state_q <= ST_HOLD;
              cnt_q   <= HOLD_LD;
              rd_n_q  <= 1'b1;
              wr_n_q  <= 1'b1;
              if (!is_wr_q) rdata_q <= {24'd0, dev_rdata_i};
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= TIMEOUT_LD;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_WAIT: begin
          // Ready on the final allowed wait cycle still counts as success.
          if (dev_ready_i || (cnt_q == 8'd0)) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_LD;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            if (!is_wr_q) rdata_q <= dev_ready_i ? {24'd0, dev_rdata_i} : 32'hFFFF_FFFF;
            if (!dev_ready_i) terr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_DONE;
            cs_n_q  <= 16'hFFFF;
            rbusy_q <= 1'b0;
            wbusy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdata_o       = rdata_q;
  assign rbusy_o       = rbusy_q;
  assign wbusy_o       = wbusy_q;
  assign dev_cs_n_o    = cs_n_q;
  assign dev_rd_n_o    = rd_n_q;
  assign dev_wr_n_o    = wr_n_q;
  assign dev_addr_o    = addr_q;
  assign dev_wdata_o   = wdata_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_io_bus_sequencer.sv
module tb_io_bus_sequencer;

  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        sel_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wmask_i;
  logic        rstrb_i;
  logic [31:0] rdata_o;
  logic        rbusy_o;
  logic        wbusy_o;
  logic [15:0] dev_cs_n_o;
  logic        dev_rd_n_o;
  logic        dev_wr_n_o;
  logic [3:0]  dev_addr_o;
  logic [7:0]  dev_wdata_o;
  logic [7:0]  dev_rdata_i;
  logic        dev_ready_i;
  logic        timeout_err_o;

  always #50 clk_i = ~clk_i;

  io_bus_sequencer #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(P), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .sel_i(sel_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wmask_i(wmask_i), .rstrb_i(rstrb_i), .rdata_o(rdata_o),
    .rbusy_o(rbusy_o), .wbusy_o(wbusy_o), .dev_cs_n_o(dev_cs_n_o),
    .dev_rd_n_o(dev_rd_n_o), .dev_wr_n_o(dev_wr_n_o), .dev_addr_o(dev_addr_o),
    .dev_wdata_o(dev_wdata_o), .dev_rdata_i(dev_rdata_i), .dev_ready_i(dev_ready_i),
    .timeout_err_o(timeout_err_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: last read result and sticky abort flag.
  logic [31:0] rdata_m = 32'd0;
  logic        terr_m  = 1'b0;

  localparam logic [31:0] IDLE_VEC = {12'd0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] bus_vec();
    return {12'd0, dev_cs_n_o, dev_rd_n_o, dev_wr_n_o, rbusy_o, wbusy_o};
  endfunction

  task automatic quiet_cpu();
    sel_i   = 1'b0;
    rstrb_i = 1'b0;
    wmask_i = 4'd0;
    addr_i  = 8'($urandom);
    wdata_i = $urandom;
  endtask

  // One CPU request. k = number of leading strobe-phase cycles with
  // dev_ready low. rst_at != 0 pulls reset low in that relative cycle.
  task automatic txn(input logic sel, input logic [7:0] a, input logic [31:0] wd,
                     input logic [3:0] wm, input logic rs, input int k,
                     input logic [7:0] drd, input int rst_at);
    logic        acc, is_wr, to;
    int          len, last, sidx;
    logic [15:0] cs_exp;
    logic [31:0] exp_vec;
    logic        in_cs, strb;
    step();
    chk("idle_bus", bus_vec(), IDLE_VEC);
    chk("idle_rdata", rdata_o, rdata_m);
    sel_i = sel; addr_i = a; wdata_i = wd; wmask_i = wm; rstrb_i = rs;
    dev_rdata_i = drd; dev_ready_i = 1'($urandom);
    acc   = sel && (rs || (wm != 4'd0));
    is_wr = (wm != 4'd0);
    if (!acc) begin
      for (int n = 1; n <= 3; n++) begin
        step();
        if (n == 1) quiet_cpu();
        chk("ignored_bus", bus_vec(), IDLE_VEC);
      end
      return;
    end
    // Strobe stays low until ready is seen at/after the minimum width,
    // capped at the minimum width plus TO wait cycles.
    len = (k + 1 < P) ? P : k + 1;
    to  = 1'b0;
    if (len > P + TO) begin
      len = P + TO;
      to  = 1'b1;
    end
    last   = S + len + H + 1;
    cs_exp = ~(16'h0001 << a[7:4]);
    for (int rel = 1; rel <= last; rel++) begin
      step();
      if (rel == 1) quiet_cpu();
      if (rst_at != 0 && rel == rst_at + 1) begin
        chk("rst_bus", bus_vec(), IDLE_VEC);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_terr", {31'd0, timeout_err_o}, 32'd0);
        chk("rst_addr", {28'd0, dev_addr_o}, 32'd0);
        chk("rst_wdata", {24'd0, dev_wdata_o}, 32'd0);
        reset_i = 1'b1;
        rdata_m = 32'd0;
        terr_m  = 1'b0;
        return;
      end
      in_cs = (rel <= S + len + H);
      strb  = (rel > S) && (rel <= S + len);
      exp_vec = {12'd0, in_cs ? cs_exp : 16'hFFFF, ~(strb && !is_wr), ~(strb && is_wr),
                 in_cs && !is_wr, in_cs && is_wr};
      chk("bus", bus_vec(), exp_vec);
      chk("rdata", rdata_o, rdata_m);
      chk("terr", {31'd0, timeout_err_o}, {31'd0, terr_m});
      if (in_cs) begin
        chk("dev_addr", {28'd0, dev_addr_o}, {28'd0, a[3:0]});
        chk("dev_wdata", {24'd0, dev_wdata_o}, {24'd0, wd[7:0]});
      end
      sidx = rel - S;
      if (strb) dev_ready_i = (sidx > k);
      else      dev_ready_i = 1'($urandom);
      if (rel == S + len) begin
        if (!is_wr) rdata_m = to ? 32'hFFFF_FFFF : {24'd0, drd};
        if (to) terr_m = 1'b1;
      end
      if (rst_at != 0 && rel == rst_at) reset_i = 1'b0;
    end
  endtask

  initial begin
    reset_i = 1'b0;
    quiet_cpu();
    dev_rdata_i = 8'd0;
    dev_ready_i = 1'b1;
    step();
    step();
    chk("reset_bus", bus_vec(), IDLE_VEC);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_addr", {28'd0, dev_addr_o}, 32'd0);
    chk("reset_wdata", {24'd0, dev_wdata_o}, 32'd0);
    chk("reset_terr", {31'd0, timeout_err_o}, 32'd0);
    reset_i = 1'b1;

    txn(1'b1, 8'h12, $urandom, 4'b0000, 1'b1, 0, 8'hA5, 0);
    txn(1'b1, 8'h03, 32'h1234_5678, 4'b0001, 1'b0, 0, 8'($urandom), 0);
    txn(1'b1, 8'h27, $urandom, 4'b0000, 1'b1, P + 2, 8'h3C, 0);
    txn(1'b1, 8'h45, $urandom, 4'b0000, 1'b1, 100, 8'h11, 0);
    txn(1'b1, 8'h9A, $urandom, 4'b0000, 1'b1, 0, 8'h5E, 0);
    txn(1'b1, 8'hB1, 32'hCAFE_F00D, 4'b1111, 1'b1, 0, 8'h77, 0);
    txn(1'b0, 8'hB1, 32'hCAFE_F00D, 4'b1111, 1'b1, 0, 8'h77, 0);
    txn(1'b1, 8'h12, $urandom, 4'b0000, 1'b1, 0, 8'h99, S + 1);
    txn(1'b1, 8'h12, $urandom, 4'b0000, 1'b1, 0, 8'hA5, 0);

    for (int i = 0; i < 40; i++) begin
      logic       rs_sel;
      logic [3:0] wm_r;
      rs_sel = ($urandom_range(0, 7) != 0);
      wm_r   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      txn(rs_sel, 8'($urandom), $urandom, wm_r, 1'($urandom),
          $urandom_range(0, 8), 8'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
